gpio_iobuf_ctrl: RTL and testbench
==================================

GPIO_IOBUF_CTRL -- requirements
Module: gpio_iobuf_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 3: number of GPIO channels, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable cycles needed to accept a new level, legal range 1..65535.
REQ-004 SHALL have parameter INIT_LEVEL, default {DATA_WIDTH{1'b0}}: per-bit reset level of the synchroniser and debounced state.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic in this domain.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port gpio_t, input, DATA_WIDTH bits: per-bit tristate from the PS; 1 = input (pad released), 0 = drive.
REQ-008 SHALL have port gpio_i, input, DATA_WIDTH bits: per-bit value the PS drives onto the pad.
REQ-009 SHALL have port gpio_o, output, DATA_WIDTH bits: synchronised, debounced pad level returned to the PS.
REQ-010 SHALL have port pad_i, input, DATA_WIDTH bits: raw asynchronous pad sample from the external IOBUF.
REQ-011 SHALL have port pad_o, output, DATA_WIDTH bits: value to the IOBUF I input.
REQ-012 SHALL have port pad_t, output, DATA_WIDTH bits: IOBUF T input; 1 = high-Z.
REQ-013 SHALL have port rise_en, input, DATA_WIDTH bits: per-bit rising-edge interrupt enable.
REQ-014 SHALL have port fall_en, input, DATA_WIDTH bits: per-bit falling-edge interrupt enable.
REQ-015 SHALL have port intr_clr, input, DATA_WIDTH bits: per-bit write-1-to-clear pulse for intr_status.
REQ-016 SHALL have port intr_status, output, DATA_WIDTH bits: sticky per-bit edge-event flags.
REQ-017 SHALL have port intr, output, 1 bit: level interrupt, the OR of all intr_status bits.

Function
REQ-018 SHALL register pad_o <= gpio_i and pad_t <= gpio_t, one cycle latency, with no combinational path from the PS to the pad.
REQ-019 SHALL pass each pad_i bit through a SYNC_STAGES-deep flop chain; the last stage is s.
REQ-020 SHALL keep a per-bit counter cnt of width clog2(DEBOUNCE_CYCLES+1), with debounced state deb.
- s == deb: cnt <= 0.
- s != deb and cnt == DEBOUNCE_CYCLES-1: deb <= s, cnt <= 0.
- otherwise: cnt <= cnt+1.
REQ-021 SHALL drive gpio_o = deb, so that a clean pad step appears on gpio_o exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges after the first edge that samples it.
REQ-022 SHALL reject any s excursion shorter than DEBOUNCE_CYCLES cycles: deb is unchanged and cnt returns to 0 when s reverts.
REQ-023 SHALL keep channels fully independent; the counters do not interact.
REQ-024 SHALL keep debouncing and edge detection running whether gpio_t is 0 or 1, since the pad is read back while it is driven.
REQ-025 SHALL register deb_d <= deb, with rise = deb & ~deb_d and fall = ~deb & deb_d.
REQ-026 SHALL set intr_status[n] <= 1 on (rise[n] & rise_en[n]) | (fall[n] & fall_en[n]), one edge after the deb change.
REQ-027 SHALL clear intr_status[n] <= 0 on intr_clr[n] when no set condition occurs in the same cycle.
REQ-028 SHALL let set win over clear when both occur in the same cycle, so the bit remains 1.
REQ-029 SHALL hold intr_status bits until cleared; disabling rise_en or fall_en does not clear already-set bits.
REQ-030 SHALL register intr <= |intr_status, one cycle after the status change.

Reset
REQ-031 SHALL, on rst=1 at a clk edge, load:
- the synchroniser stages, deb and deb_d with INIT_LEVEL;
- cnt with 0;
- intr_status and intr with 0;
- pad_t with all ones (pads released);
- pad_o with 0.
REQ-032 SHALL produce no rise or fall event at reset release, including when pad_i differs from INIT_LEVEL; in that case the difference is debounced normally and then flagged as an edge.
REQ-033 SHALL abort any debounce in progress when rst is asserted mid-count; that count is lost.
REQ-034 SHALL drive outputs to their reset values from the first edge with rst=1 and hold them while rst stays high.

Verification
REQ-035 SHALL cover a clean step: defaults, rise_en=3'b111, pad_i[0] 0->1 held -> gpio_o[0]=1 after exactly 18 edges, intr_status[0]=1 at edge 19, intr=1 at edge 20.
REQ-036 SHALL cover glitch rejection: pad_i[1] high for 15 cycles then low -> gpio_o[1] and intr_status stay 0, and cnt[1] returns to 0.
REQ-037 SHALL cover clear/set collision: intr_status[2]=1, fall_en[2]=1, and intr_clr[2] pulsed in the same cycle as a new fall event on bit 2 -> intr_status[2] stays 1; a later lone intr_clr[2] -> 0, and intr -> 0 one cycle after that.
REQ-038 SHALL cover output path and readback: gpio_t=3'b110, gpio_i=3'b001 -> pad_t=3'b110 and pad_o=3'b001 one edge later; with pad_i looped to pad_o, gpio_o[0]=1 after 18 further edges.
REQ-039 SHALL cover reset mid-debounce: pad_i[0]=1 for 10 cycles, rst pulsed high 1 cycle -> all outputs at reset values, and gpio_o[0] rises only after a full new 18-edge interval with no early update.
REQ-040 SHALL cover the edge-enable mask: rise_en=0, fall_en[0]=1, pad_i[0] 0->1->0 (each level held 40 cycles) -> only the falling transition sets intr_status[0].

Source files
------------

// File: rtl/gpio_iobuf_ctrl.sv
// GPIO pad controller: registered PS->pad drive path plus a per-channel
// synchronise/debounce/edge-detect chain with sticky edge interrupts.

module gpio_iobuf_lane #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        INIT            = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  input  logic rise_en,
  input  logic fall_en,
  input  logic intr_clr,
  output logic deb,
  output logic intr_status
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   deb_d;
  logic                   s, rise, fall, set_ev;

  assign s      = sync[SYNC_STAGES-1];
  assign rise   = deb & ~deb_d;
  assign fall   = ~deb & deb_d;
  assign set_ev = (rise & rise_en) | (fall & fall_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= {SYNC_STAGES{INIT}};
      cnt         <= '0;
      deb         <= INIT;
      deb_d       <= INIT;
      intr_status <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], pad_i};
      deb_d <= deb;
      // any reversion of s before the count completes drops the pending level
      if (s == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // a new edge outranks a same-cycle clear so no event is lost
      if (set_ev)        intr_status <= 1'b1;
      else if (intr_clr) intr_status <= 1'b0;
    end
  end
endmodule

module gpio_iobuf_ctrl #(
  parameter int unsigned           DATA_WIDTH      = 3,
  parameter int unsigned           SYNC_STAGES     = 2,
  parameter int unsigned           DEBOUNCE_CYCLES = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_LEVEL      = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] gpio_t,
  input  logic [DATA_WIDTH-1:0] gpio_i,
  output logic [DATA_WIDTH-1:0] gpio_o,
  input  logic [DATA_WIDTH-1:0] pad_i,
  output logic [DATA_WIDTH-1:0] pad_o,
  output logic [DATA_WIDTH-1:0] pad_t,
  input  logic [DATA_WIDTH-1:0] rise_en,
  input  logic [DATA_WIDTH-1:0] fall_en,
  input  logic [DATA_WIDTH-1:0] intr_clr,
  output logic [DATA_WIDTH-1:0] intr_status,
  output logic                  intr
);
  // drive path is fully registered: no PS-to-pad combinational route
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_o <= '0;
      pad_t <= '1;
      intr  <= 1'b0;
    end else begin
      pad_o <= gpio_i;
      pad_t <= gpio_t;
      intr  <= |intr_status;
    end
  end

  // readback keeps running while driven, so the lanes ignore gpio_t
  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lane
    gpio_iobuf_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT           (INIT_LEVEL[g])
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .pad_i      (pad_i[g]),
      .rise_en    (rise_en[g]),
      .fall_en    (fall_en[g]),
      .intr_clr   (intr_clr[g]),
      .deb        (gpio_o[g]),
      .intr_status(intr_status[g])
    );
  end
endmodule

// File: tb/tb_gpio_iobuf_ctrl.sv
// Directed bench for gpio_iobuf_ctrl at default parameters (3 ch, 2 sync, 16 debounce).

module tb_gpio_iobuf_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] gpio_t, gpio_i, gpio_o, pad_i, pad_o, pad_t;
  logic [2:0] rise_en, fall_en, intr_clr, intr_status;
  logic       intr;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  gpio_iobuf_ctrl dut (
    .clk(clk), .rst(rst), .gpio_t(gpio_t), .gpio_i(gpio_i), .gpio_o(gpio_o),
    .pad_i(pad_i), .pad_o(pad_o), .pad_t(pad_t), .rise_en(rise_en),
    .fall_en(fall_en), .intr_clr(intr_clr), .intr_status(intr_status), .intr(intr)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_gpio_o"}, gpio_o, 3'b000);
    chk({tag, "_pad_t"},  pad_t,  3'b111);
    chk({tag, "_pad_o"},  pad_o,  3'b000);
    chk({tag, "_status"}, intr_status, 3'b000);
    chk({tag, "_intr"},   intr,   1'b0);
  endtask

  initial begin
    rst = 1'b1; gpio_t = 3'b111; gpio_i = 3'b000; pad_i = 3'b000;
    rise_en = 3'b000; fall_en = 3'b000; intr_clr = 3'b000;
    tick();
    chk_reset_state("rst");
    tick();
    chk_reset_state("rst_hold");
    rst = 1'b0;

    // clean rising step on bit 0
    rise_en = 3'b111;
    pad_i = 3'b001;
    tick(17);
    chk("step_e17_gpio", gpio_o, 3'b000);
    tick();
    chk("step_e18_gpio", gpio_o, 3'b001);
    chk("step_e18_status", intr_status, 3'b000);
    tick();
    chk("step_e19_status", intr_status, 3'b001);
    chk("step_e19_intr", intr, 1'b0);
    tick();
    chk("step_e20_intr", intr, 1'b1);
    intr_clr = 3'b001;
    tick();
    intr_clr = 3'b000;
    chk("step_clr_status", intr_status, 3'b000);
    tick();
    chk("step_clr_intr", intr, 1'b0);

    // 15-cycle glitch on bit 1 must be rejected
    pad_i = 3'b011;
    tick(15);
    pad_i = 3'b001;
    tick(25);
    chk("glitch_gpio", gpio_o, 3'b001);
    chk("glitch_status", intr_status, 3'b000);
    chk("glitch_intr", intr, 1'b0);
    // counter must be back at 0: a real step takes the full 18 edges
    pad_i = 3'b011;
    tick(17);
    chk("post_glitch_e17", gpio_o, 3'b001);
    tick();
    chk("post_glitch_e18", gpio_o, 3'b011);
    tick();
    chk("post_glitch_status", intr_status, 3'b010);
    intr_clr = 3'b010;
    tick();
    intr_clr = 3'b000;
    tick();
    chk("post_glitch_clr_status", intr_status, 3'b000);
    chk("post_glitch_clr_intr", intr, 1'b0);

    // clear/set collision on bit 2
    rise_en = 3'b100; fall_en = 3'b100;
    pad_i = 3'b111;
    tick(19);
    chk("coll_rise_status", intr_status, 3'b100);
    pad_i = 3'b011;
    tick(18);
    chk("coll_fall_gpio", gpio_o, 3'b011);
    intr_clr = 3'b100;
    tick();
    intr_clr = 3'b000;
    chk("coll_set_wins", intr_status, 3'b100);
    intr_clr = 3'b100;
    tick();
    intr_clr = 3'b000;
    chk("coll_lone_clr", intr_status, 3'b000);
    chk("coll_intr_lag", intr, 1'b1);
    tick();
    chk("coll_intr_low", intr, 1'b0);

    // output path and loopback readback
    rise_en = 3'b000; fall_en = 3'b000;
    pad_i = 3'b000;
    tick(20);
    chk("loop_settle_gpio", gpio_o, 3'b000);
    gpio_t = 3'b110; gpio_i = 3'b001;
    chk("loop_pad_t_pre", pad_t, 3'b111);
    tick();
    chk("loop_pad_t", pad_t, 3'b110);
    chk("loop_pad_o", pad_o, 3'b001);
    pad_i = pad_o;
    tick(17);
    chk("loop_e17_gpio", gpio_o, 3'b000);
    tick();
    chk("loop_e18_gpio", gpio_o, 3'b001);
    gpio_t = 3'b111; gpio_i = 3'b000;

    // reset in the middle of a debounce
    pad_i = 3'b000;
    tick(20);
    chk("mid_settle_gpio", gpio_o, 3'b000);
    rise_en = 3'b001;
    pad_i = 3'b001;
    tick(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("mid_rst");
    tick(17);
    chk("mid_e17_gpio", gpio_o, 3'b000);
    chk("mid_e17_status", intr_status, 3'b000);
    tick();
    chk("mid_e18_gpio", gpio_o, 3'b001);
    tick();
    chk("mid_e19_status", intr_status, 3'b001);
    intr_clr = 3'b001;
    tick();
    intr_clr = 3'b000;
    tick();
    chk("mid_clr_status", intr_status, 3'b000);

    // edge-enable mask: only the falling transition may flag
    rise_en = 3'b000; fall_en = 3'b000;
    pad_i = 3'b000;
    tick(40);
    chk("mask_settle_status", intr_status, 3'b000);
    fall_en = 3'b001;
    pad_i = 3'b001;
    tick(40);
    chk("mask_rise_gpio", gpio_o, 3'b001);
    chk("mask_rise_status", intr_status, 3'b000);
    pad_i = 3'b000;
    tick(40);
    chk("mask_fall_gpio", gpio_o, 3'b000);
    chk("mask_fall_status", intr_status, 3'b001);
    chk("mask_fall_intr", intr, 1'b1);
    // disabling the enable must not drop a set bit
    fall_en = 3'b000;
    tick(2);
    chk("mask_sticky", intr_status, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
